// File: rtl/reg_pkg.sv
// reg_pkg: shared constants and address-width helper for the register file.
package reg_pkg;
    localparam int wcount_bits = 8;
    localparam logic [wcount_bits-1:0] wcount_max = 8'd255;

    function automatic int addr_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/Reg.sv
// Reg: single storage word with write enable and asynchronous active-low clear.
module Reg #(
    parameter int bits = 4
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            wenable,
    input  logic [bits-1:0] wdata,
    output logic [bits-1:0] rdata
);
    always_ff @(posedge clk or negedge rstn)
        if (!rstn) rdata <= '0;
        else if (wenable) rdata <= wdata;
endmodule

// File: rtl/reg_file.sv
// reg_file: two-read one-write register file with optional zero register,
// write-to-read bypass and a saturating count of accepted writes.
module reg_file
    import reg_pkg::*;
#(
    parameter int bits     = 4,
    parameter int count    = 8,
    parameter int zero_reg = 0,
    parameter int bypass   = 0
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          wenable,
    input  logic [addr_bits(count)-1:0]   waddr,
    input  logic [bits-1:0]               wdata,
    input  logic [addr_bits(count)-1:0]   raddr_a,
    output logic [bits-1:0]               rdata_a,
    input  logic [addr_bits(count)-1:0]   raddr_b,
    output logic [bits-1:0]               rdata_b,
    output logic [wcount_bits-1:0]        wcount
);
    localparam int aw = addr_bits(count);

    logic [bits-1:0] q [count];
    logic wacc;

    // A write counts only if it lands on a real, writable register.
    assign wacc = wenable && (int'(waddr) < count) && !(zero_reg != 0 && waddr == '0);

    for (genvar g = 0; g < count; g++) begin : g_word
        Reg #(.bits(bits)) u_reg (
            .clk(clk),
            .rstn(rstn),
            .wenable(wacc && waddr == aw'(g)),
            .wdata(wdata),
            .rdata(q[g])
        );
    end

    function automatic logic [bits-1:0] rd(input logic [aw-1:0] a);
        if (!rstn) return '0;
        if (bypass != 0 && wacc && a == waddr) return wdata;
        if (int'(a) >= count || (zero_reg != 0 && a == '0)) return '0;
        return q[a];
    endfunction

    assign rdata_a = rd(raddr_a);
    assign rdata_b = rd(raddr_b);

    always_ff @(posedge clk or negedge rstn)
        if (!rstn) wcount <= '0;
        else if (wacc && wcount != wcount_max) wcount <= wcount + 1'b1;
endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: drives a plain register file and a zero-reg/bypass/count=6 one with shared inputs.
module tb_reg_file;
    logic clk = 0;
    logic rstn = 0;
    logic we = 0;
    logic [2:0] wa = 0, ra = 0, rb = 0;
    logic [3:0] wd = 0;
    logic [3:0] rda0, rdb0, rda1, rdb1;
    logic [7:0] wc0, wc1;
    int pass_cnt = 0, total = 0;
    int m0 [8];
    int m1 [8];
    int c0, c1;

    always #5 clk = ~clk;

    reg_file dut0 (
        .clk(clk), .rstn(rstn), .wenable(we), .waddr(wa), .wdata(wd),
        .raddr_a(ra), .rdata_a(rda0), .raddr_b(rb), .rdata_b(rdb0), .wcount(wc0)
    );

    reg_file #(.bits(4), .count(6), .zero_reg(1), .bypass(1)) dut1 (
        .clk(clk), .rstn(rstn), .wenable(we), .waddr(wa), .wdata(wd),
        .raddr_a(ra), .rdata_a(rda1), .raddr_b(rb), .rdata_b(rdb1), .wcount(wc1)
    );

    typedef struct {
        logic       we;
        logic [2:0] wa;
        logic [3:0] wd;
        logic [2:0] ra, rb;
        logic [3:0] ea0, eb0, ea1, eb1;
        logic [7:0] ec0, ec1;
    } vec_t;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic bit ok1(input logic [2:0] a);
        return a != 0 && a < 6;
    endfunction

    function automatic logic [3:0] exp0(input logic [2:0] a);
        return 4'(m0[a]);
    endfunction

    function automatic logic [3:0] exp1(input logic [2:0] a);
        if (!ok1(a)) return 4'h0;
        if (we && wa == a) return wd;
        return 4'(m1[a]);
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 8; i++) begin
            m0[i] = 0;
            m1[i] = 0;
        end
        c0 = 0;
        c1 = 0;
    endtask

    task automatic check_zero(input string name);
        chk({name, "_a0"}, 8'(rda0), 8'h0);
        chk({name, "_b0"}, 8'(rdb0), 8'h0);
        chk({name, "_a1"}, 8'(rda1), 8'h0);
        chk({name, "_b1"}, 8'(rdb1), 8'h0);
        chk({name, "_c0"}, wc0, 8'h0);
        chk({name, "_c1"}, wc1, 8'h0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn = 0;
        we = 0;
        repeat (2) @(negedge clk);
        rstn = 1;
        clear_model();
    endtask

    vec_t vecs [8];

    initial begin
        vecs[0] = '{1, 3, 4'hA, 3, 5, 4'h0, 4'h0, 4'hA, 4'h0, 0, 0};
        vecs[1] = '{1, 5, 4'h5, 3, 5, 4'hA, 4'h0, 4'hA, 4'h5, 1, 1};
        vecs[2] = '{0, 0, 4'h0, 3, 5, 4'hA, 4'h5, 4'hA, 4'h5, 2, 2};
        vecs[3] = '{1, 2, 4'h1, 2, 2, 4'h0, 4'h0, 4'h1, 4'h1, 2, 2};
        vecs[4] = '{1, 2, 4'hF, 2, 3, 4'h1, 4'hA, 4'hF, 4'hA, 3, 3};
        vecs[5] = '{1, 0, 4'hF, 0, 2, 4'h0, 4'hF, 4'h0, 4'hF, 4, 4};
        vecs[6] = '{1, 7, 4'hF, 0, 7, 4'hF, 4'h0, 4'h0, 4'h0, 5, 4};
        vecs[7] = '{0, 0, 4'h0, 7, 0, 4'hF, 4'hF, 4'h0, 4'h0, 6, 4};

        // Reset held with a live write that would also hit the bypass path.
        rstn = 0; we = 1; wd = 4'hF; wa = 2; ra = 2; rb = 5;
        repeat (2) @(posedge clk);
        #1 check_zero("reset");
        @(negedge clk);
        rstn = 1; we = 0;
        clear_model();

        foreach (vecs[i]) begin
            @(negedge clk);
            we = vecs[i].we; wa = vecs[i].wa; wd = vecs[i].wd;
            ra = vecs[i].ra; rb = vecs[i].rb;
            #1;
            chk($sformatf("vec%0d_a0", i), 8'(rda0), 8'(vecs[i].ea0));
            chk($sformatf("vec%0d_b0", i), 8'(rdb0), 8'(vecs[i].eb0));
            chk($sformatf("vec%0d_a1", i), 8'(rda1), 8'(vecs[i].ea1));
            chk($sformatf("vec%0d_b1", i), 8'(rdb1), 8'(vecs[i].eb1));
            chk($sformatf("vec%0d_c0", i), wc0, vecs[i].ec0);
            chk($sformatf("vec%0d_c1", i), wc1, vecs[i].ec1);
        end

        // Randomized traffic against the array model, with occasional async reset pulses.
        do_reset();
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            we = 1'($urandom_range(0, 1));
            wa = 3'($urandom); wd = 4'($urandom);
            ra = 3'($urandom); rb = 3'($urandom);
            #1;
            chk("rnd_a0", 8'(rda0), 8'(exp0(ra)));
            chk("rnd_b0", 8'(rdb0), 8'(exp0(rb)));
            chk("rnd_a1", 8'(rda1), 8'(exp1(ra)));
            chk("rnd_b1", 8'(rdb1), 8'(exp1(rb)));
            chk("rnd_c0", wc0, 8'(c0));
            chk("rnd_c1", wc1, 8'(c1));
            if ($urandom_range(0, 31) == 0) begin
                rstn = 0;
                #1 check_zero("rnd_pulse");
                rstn = 1;
                clear_model();
            end
            if (we) begin
                m0[wa] = wd;
                if (c0 < 255) c0++;
                if (ok1(wa)) begin
                    m1[wa] = wd;
                    if (c1 < 255) c1++;
                end
            end
        end

        // Saturation, then an async pulse between edges.
        do_reset();
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            we = 1; wa = 3'($urandom_range(1, 5)); wd = 4'($urandom_range(1, 15));
        end
        @(negedge clk);
        we = 0; ra = wa; rb = wa;
        #1;
        chk("sat_c0", wc0, 8'd255);
        chk("sat_c1", wc1, 8'd255);
        chk("sat_a0", 8'(rda0), 8'(wd));
        #1 rstn = 0;
        #1 check_zero("async");
        rstn = 1;

        // A write coinciding with reset assertion is discarded.
        @(negedge clk);
        we = 1; wa = 3; wd = 4'h9; ra = 3; rb = 3;
        #4 rstn = 0;
        @(posedge clk);
        @(negedge clk);
        rstn = 1;
        #1;
        chk("rst_edge_a0", 8'(rda0), 8'h0);
        chk("rst_edge_c0", wc0, 8'h0);
        chk("rst_edge_c1", wc1, 8'h0);
        @(posedge clk);
        #1;
        chk("first_a0", 8'(rda0), 8'h9);
        chk("first_b1", 8'(rdb1), 8'h9);
        chk("first_c0", wc0, 8'd1);
        chk("first_c1", wc1, 8'd1);
        we = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("hold_a0", 8'(rda0), 8'h9);
        chk("hold_c0", wc0, 8'd1);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule

// File: doc/reg_file.md
REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 The block SHALL have parameter bits, default 4, giving the data width of each register.
REQ-002 The block SHALL have parameter count, default 8, giving the number of registers (2..256).
REQ-003 The block SHALL have parameter zero_reg, default 0; when 1, register 0 reads as zero and ignores writes.
REQ-004 The block SHALL have parameter bypass, default 0; when 1, a same-cycle write is forwarded to matching read ports.
REQ-005 The block SHALL have port clk, input, 1, the single clock; all state updates occur on its rising edge.
REQ-006 The block SHALL have port rstn, input, 1, reset: asynchronous, active-low.
REQ-007 The block SHALL have port wenable, input, 1, write strobe sampled at the rising edge of clk.
REQ-008 The block SHALL have port waddr, input, AW = max(1, $clog2(count)), the write register index.
REQ-009 The block SHALL have port wdata, input, bits, the write data.
REQ-010 The block SHALL have port raddr_a, input, AW, the read port A index.
REQ-011 The block SHALL have port rdata_a, output, bits, the read port A data.
REQ-012 The block SHALL have port raddr_b, input, AW, the read port B index.
REQ-013 The block SHALL have port rdata_b, output, bits, the read port B data.
REQ-014 The block SHALL have port wcount, output, 8, a saturating count of accepted writes since reset.

Function
REQ-015 Reads SHALL be combinational: rdata_x equals the stored value of register raddr_x with zero clock latency.
REQ-016 On a rising edge with rstn=1, wenable=1 and waddr<count, register waddr SHALL take wdata; all other registers SHALL hold.
REQ-017 A write with waddr>=count (non-power-of-two count) SHALL be ignored, and it SHALL not increment wcount.
REQ-018 A read with raddr_x>=count SHALL return all zeros.
REQ-019 With zero_reg=1, a write to index 0 SHALL be ignored (no wcount increment), and reads of index 0 SHALL return zero.
REQ-020 With bypass=1, wenable=1 and raddr_x==waddr (write accepted per REQ-016/019), rdata_x SHALL equal wdata in that same cycle.
REQ-021 With bypass=0, rdata_x SHALL show the old value until after the edge.
REQ-022 Both ports reading the same index SHALL return identical data.
REQ-023 wcount SHALL increment by 1 per accepted write and saturate at 255 (no wrap-around).
REQ-024 While wenable=0, all registers and wcount SHALL hold indefinitely.

Reset
REQ-025 Assertion of rstn=0 SHALL immediately (asynchronously, without a clock edge) clear every register and wcount to zero.
REQ-026 While rstn=0, writes SHALL be ignored, and rdata_a/rdata_b SHALL read zero, including the bypass path.
REQ-027 Reset asserted mid-operation SHALL discard any write coinciding with that edge.
REQ-028 The first accepted write SHALL occur on the first rising edge with rstn=1.

Structure
REQ-029 Shared package reg_pkg SHALL hold the address-width function, the wcount width constant (8), and the saturation limit (255).
REQ-030 Each storage word SHALL be an instance of the existing single-register cell Reg (parameter bits, ports clk/rstn/wenable/wdata/rdata), with wenable decoded per index.
REQ-031 Read multiplexing, bypass and zero-register logic SHALL live in reg_file, not in Reg.

Verification
REQ-032 Reset check: rstn=0 for 2 cycles with wenable=1, wdata=4'b1111 -> all reads 4'b0000, wcount=0.
REQ-033 Write/readback: write 4'b1010 to reg 3 and 4'b0101 to reg 5, then raddr_a=3, raddr_b=5 -> 4'b1010, 4'b0101, wcount=2.
REQ-034 Bypass: bypass=1, reg 2=4'b0001, write 4'b1111 to reg 2 with raddr_a=2 -> rdata_a=4'b1111 in the same cycle; with bypass=0 -> 4'b0001 until the edge.
REQ-035 Zero register: zero_reg=1, write 4'b1111 to reg 0 -> reads 4'b0000 and wcount unchanged; count=6, write to index 7 -> ignored, read index 7 -> 4'b0000.
REQ-036 Saturation: 300 consecutive accepted writes -> wcount=255; async rstn pulse between clock edges -> all outputs 0 immediately.
